gshare_spec_bp: RTL

- Parametrised gshare direction predictor.
- Global history is updated speculatively at fetch and repaired from a checkpoint on mispredict.
- Counter width, history length and table depth are configurable. The pattern table is initialised by a sequential sweep after reset, and the block carries built-in branch/mispredict statistics counters.
- Sits between the fetch stage, which consumes the prediction, and the execute stage, which returns resolution.

---
 rtl/gshare_spec_bp.sv | 133 +++++++++++++
 1 files changed

// File: rtl/gshare_spec_bp.sv
// gshare direction predictor with speculative global history, checkpoint repair,
// a post-reset table init sweep and saturating branch/mispredict statistics.
module gshare_spec_bp #(
    parameter int INDEX_W  = 10,
    parameter int HIST_LEN = 10,
    parameter int CTR_W    = 2,
    parameter int INIT_CTR = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_valid,
    input  logic [31:0]         fetch_pc,
    input  logic                fetch_is_br,
    output logic                pred_taken,
    output logic [INDEX_W-1:0]  pred_idx,
    output logic [HIST_LEN-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic [HIST_LEN-1:0] upd_ghr,
    input  logic                upd_taken,
    input  logic                upd_mispredict,
    output logic                ready,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
);
    localparam int              DEPTH    = 2 ** INDEX_W;
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [INDEX_W-1:0] LAST_IDX = {INDEX_W{1'b1}};

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [INDEX_W-1:0]  init_ptr_q, init_ptr_d;
    logic [HIST_LEN-1:0] ghr_q, ghr_d;
    logic [31:0]         stat_br_q, stat_br_d;
    logic [31:0]         stat_mp_q, stat_mp_d;

    logic [CTR_W-1:0]    pht_mem [DEPTH];
    logic                wr_en;
    logic [INDEX_W-1:0]  wr_idx;
    logic [CTR_W-1:0]    wr_data;

    logic                run;
    logic                upd_accept;
    logic                spec_shift;
    logic [INDEX_W-1:0]  fetch_idx;
    logic [INDEX_W-1:0]  upd_idx;
    logic [CTR_W-1:0]    upd_ctr;
    logic                unused_pc_bits;

    function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] ctr,
                                                  input logic taken);
        if (taken) return (ctr == CTR_MAX) ? ctr : ctr + 1'b1;
        return (ctr == '0) ? ctr : ctr - 1'b1;
    endfunction

    function automatic logic [31:0] stat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

    // Only the index bits of the PCs participate; the upper bits are don't-care.
    assign unused_pc_bits = ^{fetch_pc[31:INDEX_W+2], upd_pc[31:INDEX_W+2]};

    assign run        = (state_q == ST_RUN);
    assign fetch_idx  = fetch_pc[INDEX_W+1:2] ^ INDEX_W'(ghr_q);
    assign upd_idx    = upd_pc[INDEX_W+1:2] ^ INDEX_W'(upd_ghr);
    assign upd_ctr    = pht_mem[upd_idx];
    assign upd_accept = run & upd_valid & (upd_pc[1:0] == 2'b00);
    assign spec_shift = run & fetch_valid & fetch_is_br & (fetch_pc[1:0] == 2'b00);

    assign pred_taken       = run & fetch_valid & pht_mem[fetch_idx][CTR_W-1];
    assign pred_idx         = fetch_idx;
    assign pred_ghr         = ghr_q;
    assign ready            = run;
    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        ghr_d      = ghr_q;
        stat_br_d  = stat_br_q;
        stat_mp_d  = stat_mp_q;
        wr_en      = 1'b0;
        wr_idx     = upd_idx;
        wr_data    = ctr_step(upd_ctr, upd_taken);

        case (state_q)
            ST_INIT: begin
                wr_en      = 1'b1;
                wr_idx     = init_ptr_q;
                wr_data    = CTR_W'(INIT_CTR);
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == LAST_IDX) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (upd_accept) begin
                    wr_en     = 1'b1;
                    stat_br_d = stat_inc(stat_br_q);
                    if (upd_mispredict) stat_mp_d = stat_inc(stat_mp_q);
                end
                // Repair wins: the same-cycle fetch shift was down the wrong path.
                if (upd_accept && upd_mispredict)
                    ghr_d = {upd_ghr[HIST_LEN-2:0], upd_taken};
                else if (spec_shift)
                    ghr_d = {ghr_q[HIST_LEN-2:0], pred_taken};
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
            ghr_q      <= '0;
            stat_br_q  <= '0;
            stat_mp_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            ghr_q      <= ghr_d;
            stat_br_q  <= stat_br_d;
            stat_mp_q  <= stat_mp_d;
        end
    end

    // Single write port, no reset: the sweep is the only initialisation.
    always_ff @(posedge clk) begin
        if (wr_en) pht_mem[wr_idx] <= wr_data;
    end

endmodule
